// File: rtl/clct_subkey_decoder_pkg.sv
// Shared CLCT pattern widths and request layout for the 1/8-strip subkey decoder.
// Edge-clamp behaviour is selected in the top by CCLUT_EDGE_CLAMP_EN.
package clct_subkey_decoder_pkg;
  localparam int MXKEYBX = 8;
  localparam int MXXKYB  = 10;
  localparam int MXPATB  = 3;
  localparam int MXBNDB  = 5;
  localparam int MXQLTB  = 9;
  localparam int MAXHS   = 224;
  localparam int CNTW    = 16;
  localparam int STAGES  = 2;

  localparam logic [MXKEYBX-1:0] MAXHS_K  = MXKEYBX'(MAXHS);
  // Encoder wrap windows: +offset spills a few keys past the last strip, -2 wraps to the top.
  localparam logic [MXKEYBX-1:0] OVF_MAX_K = MXKEYBX'(MAXHS + 3);
  localparam logic [MXKEYBX-1:0] UNF_MIN_K = MXKEYBX'(252);
  localparam logic [MXXKYB-1:0]  LAST_SUBKEY = MXXKYB'(4 * (MAXHS - 1) + 3);

  typedef struct packed {
    logic [MXXKYB-1:0] subkey;
    logic [MXPATB-1:0] pat;
    logic [MXBNDB-1:0] bend;
    logic [MXQLTB-1:0] qlt;
  } clct_req_t;

  function automatic logic [1:0] offs_lo(input logic [1:0] sub);
    return sub - 2'd1;
  endfunction
endpackage

// File: rtl/clct_subkey_decoder_sat_counter.sv
// Saturating event counter; clear has priority over increment.
module clct_subkey_decoder_sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         global_reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clock) begin
    if (global_reset || clear) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/clct_subkey_decoder.sv
// Two-stage CLCT 1/8-strip subkey decoder with range check and event/error counters.
// Define CCLUT_EDGE_CLAMP_EN to clamp encoder wrap keys instead of flagging them.
module clct_subkey_decoder
  import clct_subkey_decoder_pkg::*;
(
  input  logic               clock,
  input  logic               global_reset,
  input  logic               clct_vld_in,
  input  logic [MXXKYB-1:0]  clct_subkey_in,
  input  logic [MXPATB-1:0]  clct_pat_in,
  input  logic [MXBNDB-1:0]  clct_bend_in,
  input  logic [MXQLTB-1:0]  clct_qlt_in,
  input  logic               cnt_clear,
  output logic               dec_vld,
  output logic [MXXKYB-1:0]  dec_subkey,
  output logic [MXKEYBX-1:0] dec_key,
  output logic [2:0]         dec_cfeb,
  output logic [4:0]         dec_hs,
  output logic               dec_qs,
  output logic               dec_es,
  output logic [1:0]         dec_offs_lo,
  output logic [MXPATB-1:0]  dec_pat,
  output logic [MXBNDB-1:0]  dec_bend,
  output logic [MXQLTB-1:0]  dec_qlt,
  output logic               dec_err,
  output logic               dec_clamp,
  output logic               err_sticky,
  output logic [CNTW-1:0]    cnt_vld,
  output logic [CNTW-1:0]    cnt_err
);
  logic [STAGES:1]    vld_pipe;
  clct_req_t          s1;
  logic [MXKEYBX-1:0] k;
  logic [MXXKYB-1:0]  nxt_subkey;
  logic               nxt_err, nxt_clamp;
  logic               s2_load;

  always_ff @(posedge clock) begin
    if (global_reset) begin
      vld_pipe <= '0;
      s1       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], clct_vld_in};
      if (clct_vld_in) s1 <= '{clct_subkey_in, clct_pat_in, clct_bend_in, clct_qlt_in};
    end
  end

  assign k       = s1.subkey[MXXKYB-1:2];
  assign s2_load = vld_pipe[1];

  always_comb begin
    nxt_subkey = s1.subkey;
    nxt_err    = 1'b0;
    nxt_clamp  = 1'b0;
    if (k >= MAXHS_K) begin
`ifdef CCLUT_EDGE_CLAMP_EN
      if (k >= UNF_MIN_K) begin
        nxt_subkey = '0;
        nxt_clamp  = 1'b1;
      end else if (k <= OVF_MAX_K) begin
        nxt_subkey = LAST_SUBKEY;
        nxt_clamp  = 1'b1;
      end else begin
        nxt_subkey = '0;
        nxt_err    = 1'b1;
      end
`else
      nxt_subkey = '0;
      nxt_err    = 1'b1;
`endif
    end
  end

  // Pulses re-evaluate every cycle; payload only moves when a word lands in S2.
  always_ff @(posedge clock) begin
    if (global_reset) begin
      dec_vld     <= 1'b0;
      dec_err     <= 1'b0;
      dec_clamp   <= 1'b0;
      dec_subkey  <= '0;
      dec_offs_lo <= '0;
      dec_pat     <= '0;
      dec_bend    <= '0;
      dec_qlt     <= '0;
      err_sticky  <= 1'b0;
    end else begin
      dec_vld   <= s2_load;
      dec_err   <= s2_load & nxt_err;
      dec_clamp <= s2_load & nxt_clamp;
      if (s2_load) begin
        dec_subkey  <= nxt_subkey;
        dec_offs_lo <= nxt_err ? 2'b00 : offs_lo(nxt_subkey[1:0]);
        dec_pat     <= s1.pat;
        dec_bend    <= s1.bend;
        dec_qlt     <= s1.qlt;
      end
      if (cnt_clear) err_sticky <= 1'b0;
      else if (s2_load && nxt_err) err_sticky <= 1'b1;
    end
  end

  assign dec_key  = dec_subkey[MXXKYB-1:2];
  assign dec_cfeb = dec_key[7:5];
  assign dec_hs   = dec_key[4:0];
  assign dec_qs   = dec_subkey[1];
  assign dec_es   = dec_subkey[0];

  clct_subkey_decoder_sat_counter #(.W(CNTW)) u_cnt_vld (
    .clock(clock), .global_reset(global_reset), .clear(cnt_clear),
    .inc(s2_load), .cnt(cnt_vld)
  );

  clct_subkey_decoder_sat_counter #(.W(CNTW)) u_cnt_err (
    .clock(clock), .global_reset(global_reset), .clear(cnt_clear),
    .inc(s2_load & nxt_err), .cnt(cnt_err)
  );
endmodule

// File: tb/tb_clct_subkey_decoder.sv
// Directed bench for clct_subkey_decoder; expectations track CCLUT_EDGE_CLAMP_EN.
module tb_clct_subkey_decoder;
  logic        clock = 1'b0;
  logic        global_reset;
  logic        clct_vld_in;
  logic [9:0]  clct_subkey_in;
  logic [2:0]  clct_pat_in;
  logic [4:0]  clct_bend_in;
  logic [8:0]  clct_qlt_in;
  logic        cnt_clear;
  logic        dec_vld, dec_qs, dec_es, dec_err, dec_clamp, err_sticky;
  logic [9:0]  dec_subkey;
  logic [7:0]  dec_key;
  logic [2:0]  dec_cfeb;
  logic [4:0]  dec_hs;
  logic [1:0]  dec_offs_lo;
  logic [2:0]  dec_pat;
  logic [4:0]  dec_bend;
  logic [8:0]  dec_qlt;
  logic [15:0] cnt_vld, cnt_err;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  clct_subkey_decoder dut (
    .clock(clock), .global_reset(global_reset), .clct_vld_in(clct_vld_in),
    .clct_subkey_in(clct_subkey_in), .clct_pat_in(clct_pat_in),
    .clct_bend_in(clct_bend_in), .clct_qlt_in(clct_qlt_in), .cnt_clear(cnt_clear),
    .dec_vld(dec_vld), .dec_subkey(dec_subkey), .dec_key(dec_key),
    .dec_cfeb(dec_cfeb), .dec_hs(dec_hs), .dec_qs(dec_qs), .dec_es(dec_es),
    .dec_offs_lo(dec_offs_lo), .dec_pat(dec_pat), .dec_bend(dec_bend),
    .dec_qlt(dec_qlt), .dec_err(dec_err), .dec_clamp(dec_clamp),
    .err_sticky(err_sticky), .cnt_vld(cnt_vld), .cnt_err(cnt_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [9:0] sk, input logic [2:0] p,
                       input logic [4:0] b, input logic [8:0] q);
    clct_vld_in = v; clct_subkey_in = sk; clct_pat_in = p; clct_bend_in = b; clct_qlt_in = q;
  endtask

  initial begin
    global_reset = 1'b1; cnt_clear = 1'b0;
    drive(1'b0, 10'd0, 3'd0, 5'd0, 9'd0);
    repeat (3) tick();
    chk("rst_vld", 32'(dec_vld), 32'd0);
    chk("rst_subkey", 32'(dec_subkey), 32'd0);
    chk("rst_cnt_vld", 32'(cnt_vld), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    global_reset = 1'b0;
    tick();

    // Subkey 421: key 105 -> cfeb 3, hs 9, sub 01
    drive(1'b1, 10'd421, 3'd5, 5'd17, 9'd300); tick();
    drive(1'b0, 10'd0, 3'd0, 5'd0, 9'd0); tick();
    chk("t1_vld_early", 32'(dec_vld), 32'd1);
    chk("t1_key", 32'(dec_key), 32'd105);
    chk("t1_cfeb", 32'(dec_cfeb), 32'd3);
    chk("t1_hs", 32'(dec_hs), 32'd9);
    chk("t1_qs", 32'(dec_qs), 32'd0);
    chk("t1_es", 32'(dec_es), 32'd1);
    chk("t1_offs", 32'(dec_offs_lo), 32'd0);
    chk("t1_pat", 32'(dec_pat), 32'd5);
    chk("t1_bend", 32'(dec_bend), 32'd17);
    chk("t1_qlt", 32'(dec_qlt), 32'd300);
    chk("t1_err", 32'(dec_err), 32'd0);
    chk("t1_cnt_vld", 32'(cnt_vld), 32'd1);
    tick();
    chk("t1_vld_pulse", 32'(dec_vld), 32'd0);
    chk("t1_key_hold", 32'(dec_key), 32'd105);

    // Back-to-back: 0, 895, 4
    drive(1'b1, 10'd0, 3'd1, 5'd1, 9'd1); tick();
    drive(1'b1, 10'd895, 3'd2, 5'd2, 9'd2); tick();
    drive(1'b1, 10'd4, 3'd3, 5'd3, 9'd3);
    chk("b2b0_vld", 32'(dec_vld), 32'd1);
    chk("b2b0_key", 32'(dec_key), 32'd0);
    chk("b2b0_offs", 32'(dec_offs_lo), 32'd3);
    tick();
    drive(1'b0, 10'd0, 3'd0, 5'd0, 9'd0);
    chk("b2b1_vld", 32'(dec_vld), 32'd1);
    chk("b2b1_key", 32'(dec_key), 32'd223);
    chk("b2b1_cfeb", 32'(dec_cfeb), 32'd6);
    chk("b2b1_hs", 32'(dec_hs), 32'd31);
    chk("b2b1_offs", 32'(dec_offs_lo), 32'd2);
    chk("b2b1_pat", 32'(dec_pat), 32'd2);
    tick();
    chk("b2b2_vld", 32'(dec_vld), 32'd1);
    chk("b2b2_key", 32'(dec_key), 32'd1);
    chk("b2b2_es", 32'(dec_es), 32'd0);
    chk("b2b2_err", 32'(dec_err), 32'd0);
    chk("b2b_cnt_vld", 32'(cnt_vld), 32'd4);
    tick();
    chk("b2b_vld_end", 32'(dec_vld), 32'd0);

    // Subkey 900: key 225
    drive(1'b1, 10'd900, 3'd4, 5'd9, 9'd77); tick();
    drive(1'b0, 10'd0, 3'd0, 5'd0, 9'd0); tick();
    chk("k225_vld", 32'(dec_vld), 32'd1);
    chk("k225_qlt", 32'(dec_qlt), 32'd77);
`ifdef CCLUT_EDGE_CLAMP_EN
    chk("k225_subkey", 32'(dec_subkey), 32'd895);
    chk("k225_clamp", 32'(dec_clamp), 32'd1);
    chk("k225_err", 32'(dec_err), 32'd0);
    chk("k225_cnt_err", 32'(cnt_err), 32'd0);
    chk("k225_sticky", 32'(err_sticky), 32'd0);
`else
    chk("k225_err", 32'(dec_err), 32'd1);
    chk("k225_key", 32'(dec_key), 32'd0);
    chk("k225_cfeb", 32'(dec_cfeb), 32'd0);
    chk("k225_hs", 32'(dec_hs), 32'd0);
    chk("k225_clamp", 32'(dec_clamp), 32'd0);
    chk("k225_cnt_err", 32'(cnt_err), 32'd1);
    chk("k225_sticky", 32'(err_sticky), 32'd1);
`endif
    tick();
    chk("k225_err_pulse", 32'(dec_err), 32'd0);
    chk("k225_clamp_pulse", 32'(dec_clamp), 32'd0);

    // Subkey 1020: key 255
    drive(1'b1, 10'd1020, 3'd0, 5'd0, 9'd0); tick();
    drive(1'b0, 10'd0, 3'd0, 5'd0, 9'd0); tick();
`ifdef CCLUT_EDGE_CLAMP_EN
    chk("k255_subkey", 32'(dec_subkey), 32'd0);
    chk("k255_clamp", 32'(dec_clamp), 32'd1);
    chk("k255_offs", 32'(dec_offs_lo), 32'd3);
    chk("k255_err", 32'(dec_err), 32'd0);
`else
    chk("k255_err", 32'(dec_err), 32'd1);
    chk("k255_cnt_err", 32'(cnt_err), 32'd2);
`endif
    tick();

    // Subkey 960: key 240 is an error in both builds
    drive(1'b1, 10'd960, 3'd0, 5'd0, 9'd0); tick();
    drive(1'b0, 10'd0, 3'd0, 5'd0, 9'd0); tick();
    chk("k240_err", 32'(dec_err), 32'd1);
    chk("k240_offs", 32'(dec_offs_lo), 32'd0);
`ifdef CCLUT_EDGE_CLAMP_EN
    chk("k240_cnt_err", 32'(cnt_err), 32'd1);
`else
    chk("k240_cnt_err", 32'(cnt_err), 32'd3);
`endif
    chk("k240_sticky", 32'(err_sticky), 32'd1);
    chk("pre_clr_cnt_vld", 32'(cnt_vld), 32'd7);
    tick();
    cnt_clear = 1'b1; tick();
    cnt_clear = 1'b0;
    chk("clr_sticky", 32'(err_sticky), 32'd0);
    chk("clr_cnt_err", 32'(cnt_err), 32'd0);
    chk("clr_cnt_vld", 32'(cnt_vld), 32'd0);
    chk("clr_key_hold", 32'(dec_key), 32'd0);

    // Saturation: 65537 words
    drive(1'b1, 10'd8, 3'd0, 5'd0, 9'd0);
    repeat (65537) tick();
    drive(1'b0, 10'd0, 3'd0, 5'd0, 9'd0);
    repeat (3) tick();
    chk("sat_cnt_vld", 32'(cnt_vld), 32'd65535);
    chk("sat_cnt_err", 32'(cnt_err), 32'd0);

    // Clear on the same edge that delivers a dec_vld
    drive(1'b1, 10'd8, 3'd0, 5'd0, 9'd0); tick();
    drive(1'b0, 10'd0, 3'd0, 5'd0, 9'd0);
    cnt_clear = 1'b1; tick();
    cnt_clear = 1'b0;
    chk("clrwin_vld", 32'(dec_vld), 32'd1);
    chk("clrwin_cnt_vld", 32'(cnt_vld), 32'd0);
    tick();

    // Reset while a word sits in S1
    drive(1'b1, 10'd421, 3'd7, 5'd31, 9'd511); tick();
    drive(1'b0, 10'd0, 3'd0, 5'd0, 9'd0);
    global_reset = 1'b1; tick();
    chk("mid_rst_vld", 32'(dec_vld), 32'd0);
    chk("mid_rst_key", 32'(dec_key), 32'd0);
    global_reset = 1'b0; tick();
    chk("post_rst_vld0", 32'(dec_vld), 32'd0);
    tick();
    chk("post_rst_vld1", 32'(dec_vld), 32'd0);
    chk("post_rst_qlt", 32'(dec_qlt), 32'd0);
    chk("post_rst_cnt_vld", 32'(cnt_vld), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clct_subkey_decoder.md
Name: clct_subkey_decoder

Overview:
- Receive-side counterpart of the 1-of-7 ccLUT pattern sorter/encoder. Unpacks the 10-bit 1/8-strip CLCT key word back into its fields: CFEB index, half-strip within the CFEB, quarter-strip bit, eighth-strip bit and low comparator-offset bits.
- Range-checks each word and keeps event and error counters.
- Sits on the sorter output path, feeding readout, VME status and downstream consumers of the legacy half-strip key.

Parameters:
- MXKEYBX, 8, full half-strip key width (0..223)
- MXXKYB, 10, 1/8-strip subkey width, {key[7:0], sub[1:0]}
- MXPATB, 3, pattern id width
- MXBNDB, 5, bend width
- MXQLTB, 9, quality width
- MAXHS, 224, half-strips per chamber (7 CFEBs x 32)
- CNTW, 16, counter width

Ports:
- clock  in  1  main 40 MHz clock
- global_reset  in  1  synchronous, active-high reset
- clct_vld_in  in  1  CLCT word valid, one cycle per CLCT
- clct_subkey_in  in  MXXKYB  encoded 1/8-strip key
- clct_pat_in  in  MXPATB  pattern id, passed through
- clct_bend_in  in  MXBNDB  bend, passed through
- clct_qlt_in  in  MXQLTB  quality, passed through
- cnt_clear  in  1  clears counters and sticky error
- dec_vld  out  1  decoded word valid, single-cycle pulse
- dec_subkey  out  MXXKYB  subkey after optional clamp
- dec_key  out  MXKEYBX  half-strip key, dec_subkey[9:2]
- dec_cfeb  out  3  key[7:5]
- dec_hs  out  5  key[4:0]
- dec_qs  out  1  quarter-strip bit, dec_subkey[1]
- dec_es  out  1  eighth-strip bit, dec_subkey[0]
- dec_offs_lo  out  2  recovered offs[1:0] = dec_subkey[1:0]-1 mod 4
- dec_pat, dec_bend, dec_qlt  out  MXPATB/MXBNDB/MXQLTB  passthrough
- dec_err  out  1  range error, coincident with dec_vld
- dec_clamp  out  1  edge clamp applied, coincident with dec_vld
- err_sticky  out  1  set by any dec_err; cleared only by cnt_clear or reset
- cnt_vld  out  CNTW  count of decoded words
- cnt_err  out  CNTW  count of range errors

Behaviour:
- Clocking and reset: one clock. global_reset is synchronous and active-high; all registers and outputs reset to 0.
- Pipeline: two register stages, no backpressure.
  - S1 registers the inputs.
  - S2 decodes and registers the outputs.
  - clct_vld_in at edge N gives dec_vld at edge N+2.
  - Back-to-back valid inputs on every cycle are supported with no gaps.
- Output holding: payload outputs update only when a valid word reaches S2 and hold otherwise. dec_vld, dec_err and dec_clamp are single-cycle pulses.
- Range check: let k = clct_subkey_in[9:2].
  - k < MAXHS: normal decode.
  - k >= MAXHS (and not clamped, see Optional Feature): dec_err = 1; dec_subkey, dec_key, dec_cfeb, dec_hs, dec_qs, dec_es and dec_offs_lo are forced to 0. Passthrough fields are still delivered.
- Counters: cnt_vld increments on each dec_vld; cnt_err on each dec_err.
  - Both saturate at 2^CNTW-1.
  - cnt_clear is synchronous; when it coincides with an increment, clear wins (result 0).
  - cnt_clear also clears err_sticky, but does not disturb the pipeline.
- Reset mid-flight: words in S1/S2 are discarded; no dec_vld is produced for them after reset deasserts.
- Arithmetic: dec_offs_lo uses 2-bit modular subtraction (00 -> 11).

Optional Feature:
- Macro: CCLUT_EDGE_CLAMP_EN.
- Defined: out-of-range keys caused by the encoder's -2/+offset wrap are clamped instead of flagged. Neither clamp case sets dec_err or increments cnt_err.
  - k in 252..255 (underflow wrap): dec_subkey = 0, dec_clamp = 1.
  - k in 224..227 (overflow past the last strip): dec_subkey = 4*223+3 = 895, dec_clamp = 1.
  - k in 228..251: still dec_err.
- Undefined: dec_clamp is tied to 0, and every k >= 224 produces dec_err.

Decomposition:
- Shared constants: MXKEYBX, MXXKYB, MXPATB, MXBNDB, MXQLTB and MAXHS live in the common pattern_params include, shared with the sorter.
- One natural sub-module: sat_counter (CNTW-wide saturating counter with clear priority), instantiated twice.

Test Plan:
- Subkey 421 (key 105, sub 01) at cycle N -> dec_vld at N+2; cfeb 3, hs 9, qs 0, es 1, offs_lo 0, cnt_vld 1.
- Subkeys 0, 895, 4 on three consecutive cycles -> three consecutive dec_vld; outputs key 0/223/1; cnt_vld 3; no dec_err.
- Subkey 900 (key 225):
  - Macro off -> dec_err 1, key/cfeb/hs 0, cnt_err 1, err_sticky 1.
  - Macro on -> dec_subkey 895, dec_clamp 1, cnt_err 0.
- Subkey 1020 (key 255):
  - Macro on -> dec_subkey 0, dec_clamp 1.
  - Macro off -> dec_err 1.
  - Then cnt_clear -> err_sticky 0, cnt_err 0.
- 65537 consecutive valid words -> cnt_vld 65535 (saturated); cnt_clear asserted on the same cycle as a dec_vld -> cnt_vld 0.
- Valid word at N, global_reset high at N+1 -> no dec_vld at N+2 or later for that word; all outputs read 0.
